alu16_sliced_reg: RTL and testbench
===================================

Name: alu16_sliced_reg

Overview:
- Registered WIDTH-bit ALU built from WIDTH identical 1-bit slices.
- Each slice contains:
  - two 2:1 invert muxes, one for A and one for B;
  - a 1-bit full adder;
  - a 5-way result mux selecting AND, SLT, OR, XOR or ADD.
- Slices are chained by ripple carry. Results, carry and zero flags are captured in output registers with one-cycle latency.
- Sits in the 16-bit CPU execute stage between the register-file read ports and the writeback path.

Parameters:
- WIDTH, 16, operand and result width in bits (minimum 2).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  capture enable; when low, output registers hold
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- ainvert  in  1  invert A inside every slice before use
- binvert  in  1  invert B inside every slice; also the ripple carry-in for op 100
- op  in  3  operation select
- result  out  WIDTH  registered result
- carry_out  out  1  registered carry out of the MSB slice
- zero  out  1  registered flag, 1 when the next result value is all zeros

Behaviour:
- Slice operands:
  - mA = ainvert ? ~a[i] : a[i]
  - mB = binvert_eff ? ~b[i] : b[i]
  - binvert_eff = 1 when op==001, else binvert.
- Ripple carry:
  - cin[0] = binvert_eff; cin[i+1] = cout[i].
  - Slice sum[i] = mA^mB^cin[i].
- Op encoding, per slice:
  - 000 AND: mA&mB. With ainvert=binvert=1 this gives NOR.
  - 001 SLT: bit 0 = less; bits 1..WIDTH-1 = 0.
  - 010 OR: mA|mB.
  - 011 XOR: mA^mB.
  - 100 ADD/SUB: sum[i]. binvert=0 gives a+b (+cin); binvert=1 gives a-b in two's complement.
  - 101, 110, 111: result 0, carry_out 0.
- SLT:
  - Datapath performs a + ~b + 1; B inversion and carry-in are forced to 1 regardless of the binvert input.
  - Signed compare: less = sum[WIDTH-1] ^ ovf.
  - ovf = cin[WIDTH-1] ^ cout[WIDTH-1].
  - less is routed from the MSB slice back into the Less input of slice 0.
- carry_out:
  - cout[WIDTH-1] when op is 100 or 001;
  - 0 for all other ops.
- zero: reduction NOR of the next result value, captured in the same cycle as result.
- Latency:
  - All combinational paths are computed in the cycle the inputs are present.
  - Outputs update on the rising clk edge where en=1, so they are visible one cycle after input.
  - en=0 holds all registers.
- Reset:
  - rst_n low asynchronously forces result=0, carry_out=0, zero=1.
  - This applies immediately, including mid-operation, and overrides en.
  - After release, the first capture occurs on the first rising edge with en=1.
- Wrap-around: ADD overflow discards bit WIDTH; the carry is reported only via carry_out.
- Implementation:
  - Generate loop of slice instances.
  - Separate 2:1 mux, full-adder and 5:1 mux submodules.
  - No latches; all registers use the async active-low reset.

Optional Feature:
- Macro ALU_OVERFLOW_EN.
- Defined:
  - Adds output port overflow (1 bit, registered, reset value 0).
  - overflow = cin[WIDTH-1] ^ cout[WIDTH-1] for ops 100 and 001, else 0.
  - Captured under the same en and reset rules as the other outputs.
- Undefined:
  - Port and register are absent.
  - The signed-overflow term is still computed internally for SLT, so SLT behaviour is identical either way.

Test Plan:
- Logic ops: a=0x00FF, b=0x0F0F, ainvert=binvert=0, en=1.
  - op=000 -> 0x000F
  - op=010 -> 0x0FFF
  - op=011 -> 0x0FF0
  - carry_out=0 and zero=0 for all three, one cycle later.
- NOR and undefined op: a=0x00FF, b=0x0F0F, ainvert=binvert=1, op=000 -> 0xF000.
  - Then op=101 -> result 0x0000, zero=1, carry_out=0.
- ADD: op=100, binvert=0.
  - 0x1234+0x0001 -> 0x1235, carry_out=0.
  - 0xFFFF+0x0001 -> 0x0000, carry_out=1, zero=1 (overflow=0 if ALU_OVERFLOW_EN).
  - 0x7FFF+0x0001 -> 0x8000 (overflow=1 if ALU_OVERFLOW_EN).
- SUB: op=100, binvert=1.
  - 0x0005-0x0003 -> 0x0002, carry_out=1.
  - 0x0003-0x0005 -> 0xFFFE, carry_out=0.
  - 0x0005-0x0005 -> 0x0000, zero=1.
- SLT: op=001, binvert=0 (the forced subtract must ignore binvert).
  - a=0xFFFE, b=0x0001 -> 0x0001.
  - a=0x0001, b=0xFFFE -> 0x0000.
  - a=0x7FFF, b=0x8000 -> 0x0000 (overflow-corrected).
  - a=0x8000, b=0x7FFF -> 0x0001.
- Enable and reset: capture 0x1235.
  - Drop en, change inputs -> outputs hold 0x1235.
  - Assert rst_n=0 between clock edges -> result=0, carry_out=0, zero=1 immediately.
  - Release, en=1 -> next edge captures new result.

Source files
------------

// File: rtl/alu16_sliced_reg.sv
// ---------------------------------------------------------------------------
// alu16_sliced_reg
//
// Registered WIDTH-bit ALU for the execute stage of the 16-bit CPU. It sits
// between the register-file read ports and the writeback path. The ALU is
// built from WIDTH identical 1-bit slices chained by ripple carry. Each
// slice contains:
//   - an A invert mux and a B invert mux,
//   - a full adder,
//   - a 5-way result mux.
// Result, carry and zero flags are registered, giving one cycle of latency.
//
// Optional build macro:
//   ALU_OVERFLOW_EN - adds a registered signed-overflow output for ADD/SUB
//                     and SLT. When the macro is undefined, the port is
//                     absent, but the overflow term is still used for SLT.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   en         in   1      capture enable; low holds every output register
//   a, b       in   WIDTH  operands
//   ainvert    in   1      invert A in every slice
//   binvert    in   1      invert B in every slice; also carry-in for ADD/SUB
//   op         in   3      000 AND, 001 SLT, 010 OR, 011 XOR, 100 ADD/SUB,
//                          101..111 give zero
//   result     out  WIDTH  registered result
//   carry_out  out  1      registered MSB carry (ADD/SUB and SLT only)
//   zero       out  1      registered flag, set when result is all zeros
//   overflow   out  1      (ALU_OVERFLOW_EN only) registered signed overflow
// ---------------------------------------------------------------------------

module alu_mux2 (
    input  logic d0,
    input  logic d1,
    input  logic sel,
    output logic y
);
    assign y = sel ? d1 : d0;
endmodule

module alu_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module alu_mux5 (
    input  logic       d0,
    input  logic       d1,
    input  logic       d2,
    input  logic       d3,
    input  logic       d4,
    input  logic [2:0] sel,
    output logic       y
);
    always_comb begin
        y = 1'b0;
        case (sel)
            3'b000:  y = d0;
            3'b001:  y = d1;
            3'b010:  y = d2;
            3'b011:  y = d3;
            3'b100:  y = d4;
            default: y = 1'b0;
        endcase
    end
endmodule

module alu_slice #(
    parameter bit IS_MSB = 1'b0
) (
    input  logic       a,
    input  logic       b,
    input  logic       ainvert,
    input  logic       binvert,
    input  logic       cin,
    input  logic       less,
    input  logic [2:0] op,
    output logic       result,
    output logic       cout,
    output logic       msb_sum
);
    logic ma;
    logic mb;
    logic sum;

    alu_mux2 u_amux (.d0(a), .d1(~a), .sel(ainvert), .y(ma));
    alu_mux2 u_bmux (.d0(b), .d1(~b), .sel(binvert), .y(mb));

    alu_full_adder u_fa (.a(ma), .b(mb), .cin(cin), .sum(sum), .cout(cout));

    alu_mux5 u_rmux (
        .d0  (ma & mb),
        .d1  (less),
        .d2  (ma | mb),
        .d3  (ma ^ mb),
        .d4  (sum),
        .sel (op),
        .y   (result)
    );

    // Only the MSB slice exposes its sum (the sign bit used for SLT); the
    // other slices drive 0, so the top level can simply OR the bits together.
    assign msb_sum = IS_MSB ? sum : 1'b0;
endmodule

module alu16_sliced_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ainvert,
    input  logic             binvert,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero
`ifdef ALU_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);
    logic             binv_eff_p0;
    logic [WIDTH-1:0] result_p0;
    logic [WIDTH-1:0] msb_sum_p0;
    logic             cin_msb_p0;
    logic             cout_msb_p0;
    logic             ovf_p0;
    logic             less_p0;
    logic             arith_p0;

    // SLT always performs a + ~b + 1, whatever binvert says.
    assign binv_eff_p0 = (op == 3'b001) | binvert;

    // Stage p0: combinational slice chain.
    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        logic cin_w;
        logic cout_w;

        if (i == 0) begin : g_cin0
            assign cin_w = binv_eff_p0;
        end else begin : g_cinn
            assign cin_w = g_slice[i-1].cout_w;
        end

        alu_slice #(.IS_MSB(i == WIDTH - 1)) u_slice (
            .a       (a[i]),
            .b       (b[i]),
            .ainvert (ainvert),
            .binvert (binv_eff_p0),
            .cin     (cin_w),
            .less    ((i == 0) ? less_p0 : 1'b0),
            .op      (op),
            .result  (result_p0[i]),
            .cout    (cout_w),
            .msb_sum (msb_sum_p0[i])
        );
    end

    assign cin_msb_p0  = g_slice[WIDTH-1].cin_w;
    assign cout_msb_p0 = g_slice[WIDTH-1].cout_w;
    assign ovf_p0      = cin_msb_p0 ^ cout_msb_p0;
    // Sign of the difference, corrected for signed overflow, feeds slice 0.
    assign less_p0     = (|msb_sum_p0) ^ ovf_p0;
    assign arith_p0    = (op == 3'b100) | (op == 3'b001);

    // Stage p1: output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b1;
        end else if (en) begin
            result    <= result_p0;
            carry_out <= arith_p0 & cout_msb_p0;
            zero      <= ~|result_p0;
        end
    end

`ifdef ALU_OVERFLOW_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (en) begin
            overflow <= arith_p0 & ovf_p0;
        end
    end
`endif

endmodule

// File: tb/tb_alu16_sliced_reg.sv
module tb_alu16_sliced_reg;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] a;
    logic [15:0] b;
    logic        ainvert;
    logic        binvert;
    logic [2:0]  op;
    logic [15:0] result;
    logic        carry_out;
    logic        zero;
`ifdef ALU_OVERFLOW_EN
    logic        overflow;
`endif

    int checks = 0;
    int errors = 0;

    alu16_sliced_reg #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .a         (a),
        .b         (b),
        .ainvert   (ainvert),
        .binvert   (binvert),
        .op        (op),
        .result    (result),
        .carry_out (carry_out),
        .zero      (zero)
`ifdef ALU_OVERFLOW_EN
        ,
        .overflow  (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    // Drive one operation at the falling edge, then sample just after the
    // capturing rising edge.
    task automatic run(input logic [15:0] ta, input logic [15:0] tb_,
                       input logic tai, input logic tbi, input logic [2:0] top);
        @(negedge clk);
        a       = ta;
        b       = tb_;
        ainvert = tai;
        binvert = tbi;
        op      = top;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        a       = '0;
        b       = '0;
        ainvert = 1'b0;
        binvert = 1'b0;
        op      = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_result", result, 16'h0000);
        check("rst_carry", {15'd0, carry_out}, 16'd0);
        check("rst_zero", {15'd0, zero}, 16'd1);
`ifdef ALU_OVERFLOW_EN
        check("rst_ovf", {15'd0, overflow}, 16'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;

        // Logic ops
        run(16'h00FF, 16'h0F0F, 1'b0, 1'b0, 3'b000);
        check("and", result, 16'h000F);
        check("and_c", {15'd0, carry_out}, 16'd0);
        check("and_z", {15'd0, zero}, 16'd0);
        run(16'h00FF, 16'h0F0F, 1'b0, 1'b0, 3'b010);
        check("or", result, 16'h0FFF);
        check("or_z", {15'd0, zero}, 16'd0);
        run(16'h00FF, 16'h0F0F, 1'b0, 1'b0, 3'b011);
        check("xor", result, 16'h0FF0);
        check("xor_c", {15'd0, carry_out}, 16'd0);

        // NOR and undefined op
        run(16'h00FF, 16'h0F0F, 1'b1, 1'b1, 3'b000);
        check("nor", result, 16'hF000);
        check("nor_z", {15'd0, zero}, 16'd0);
        run(16'h00FF, 16'h0F0F, 1'b1, 1'b1, 3'b101);
        check("op101", result, 16'h0000);
        check("op101_z", {15'd0, zero}, 16'd1);
        check("op101_c", {15'd0, carry_out}, 16'd0);
        run(16'hFFFF, 16'h0001, 1'b0, 1'b0, 3'b111);
        check("op111", result, 16'h0000);
        check("op111_c", {15'd0, carry_out}, 16'd0);

        // ADD
        run(16'h1234, 16'h0001, 1'b0, 1'b0, 3'b100);
        check("add", result, 16'h1235);
        check("add_c", {15'd0, carry_out}, 16'd0);
        run(16'hFFFF, 16'h0001, 1'b0, 1'b0, 3'b100);
        check("add_wrap", result, 16'h0000);
        check("add_wrap_c", {15'd0, carry_out}, 16'd1);
        check("add_wrap_z", {15'd0, zero}, 16'd1);
`ifdef ALU_OVERFLOW_EN
        check("add_wrap_ovf", {15'd0, overflow}, 16'd0);
`endif
        run(16'h7FFF, 16'h0001, 1'b0, 1'b0, 3'b100);
        check("add_sovf", result, 16'h8000);
        check("add_sovf_c", {15'd0, carry_out}, 16'd0);
`ifdef ALU_OVERFLOW_EN
        check("add_sovf_ovf", {15'd0, overflow}, 16'd1);
`endif

        // SUB
        run(16'h0005, 16'h0003, 1'b0, 1'b1, 3'b100);
        check("sub", result, 16'h0002);
        check("sub_c", {15'd0, carry_out}, 16'd1);
        run(16'h0003, 16'h0005, 1'b0, 1'b1, 3'b100);
        check("sub_neg", result, 16'hFFFE);
        check("sub_neg_c", {15'd0, carry_out}, 16'd0);
        run(16'h0005, 16'h0005, 1'b0, 1'b1, 3'b100);
        check("sub_eq", result, 16'h0000);
        check("sub_eq_z", {15'd0, zero}, 16'd1);
        check("sub_eq_c", {15'd0, carry_out}, 16'd1);

        // SLT with binvert low: the subtract is forced internally
        run(16'hFFFE, 16'h0001, 1'b0, 1'b0, 3'b001);
        check("slt_neg", result, 16'h0001);
        check("slt_neg_c", {15'd0, carry_out}, 16'd1);
        run(16'h0001, 16'hFFFE, 1'b0, 1'b0, 3'b001);
        check("slt_pos", result, 16'h0000);
        check("slt_pos_z", {15'd0, zero}, 16'd1);
        run(16'h7FFF, 16'h8000, 1'b0, 1'b0, 3'b001);
        check("slt_ovf0", result, 16'h0000);
`ifdef ALU_OVERFLOW_EN
        check("slt_ovf0_ovf", {15'd0, overflow}, 16'd1);
`endif
        run(16'h8000, 16'h7FFF, 1'b0, 1'b0, 3'b001);
        check("slt_ovf1", result, 16'h0001);
        check("slt_ovf1_z", {15'd0, zero}, 16'd0);

        // Enable hold
        run(16'h1234, 16'h0001, 1'b0, 1'b0, 3'b100);
        check("cap", result, 16'h1235);
        @(negedge clk);
        en = 1'b0;
        a  = 16'h0000;
        b  = 16'h0000;
        op = 3'b000;
        @(posedge clk);
        #1;
        check("hold", result, 16'h1235);
        check("hold_z", {15'd0, zero}, 16'd0);

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_result", result, 16'h0000);
        check("arst_carry", {15'd0, carry_out}, 16'd0);
        check("arst_zero", {15'd0, zero}, 16'd1);
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        a     = 16'h0003;
        b     = 16'h0004;
        op    = 3'b100;
        @(posedge clk);
        #1;
        check("post_rst", result, 16'h0007);
        check("post_rst_z", {15'd0, zero}, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
